player_step_ctrl: RTL and testbench
===================================

Name: player_step_ctrl

Overview:
Converts the player's two raw push-button levels into judged moves for the race game. It debounces the left and right keys and compares each press with the next box bit from the box shifter. On a correct press it emits a one-cycle advance pulse that drives the shifter and decrements the player's remaining-box count, kept as two BCD digits for the HEX7/HEX6 decoders. It sits between the KEY inputs and the shifter / player score display, replacing the ad-hoc edge-triggered player logic.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles (10 ms at 50 MHz) before a key level is accepted.
DB_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.
START_TENS, 3, reset value of the tens digit of the remaining-box count.
START_ONES, 2, reset value of the ones digit of the remaining-box count.
PENALTY_CYCLES, 25000000, lockout length after a wrong press; used only with the optional feature.

Ports:
clk  in  1  system clock (CLOCK_50).
resetn  in  1  asynchronous active-low reset.
enable  in  1  game running (SW[0]).
left  in  1  left key, active-high (already inverted from KEY[3]).
right  in  1  right key, active-high (already inverted from KEY[2]).
box  in  1  next box position from the shifter: 0 = left, 1 = right.
advance  out  1  one-cycle pulse on a correct press; drives the shifter's shift/clock-enable.
wrong  out  1  one-cycle pulse on a wrong press.
score_ones  out  4  BCD ones digit of boxes remaining.
score_tens  out  4  BCD tens digit of boxes remaining.
finished  out  1  high once the count reaches 00; stays high until reset.
penalty_active  out  1  high while the wrong-press lockout runs; tied 0 without PENALTY_EN.

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; advance=0, wrong=0, finished=0, penalty_active=0; score_tens=START_TENS, score_ones=START_ONES; synchronisers, debounced levels and debounce counters cleared to 0.
- Key path: each key passes through a 2-FF synchroniser, then a debouncer. The debounced level updates only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. A press is a 0->1 transition of a debounced level, registered as a one-cycle edge flag.
- FSM states:
  - IDLE: go to ARM when enable=1 and finished=0.
  - ARM: wait until both debounced keys are 0, then go to READY. A key already held at start is ignored.
  - READY: act on a press edge.
    - Correct: exactly one edge, and either (left with box=0) or (right with box=1). Assert advance for the next cycle, decrement the score, go to RELEASE.
    - Wrong: the opposite key, or both edges in the same cycle. Assert wrong for the next cycle, go to RELEASE.
  - RELEASE: wait until both debounced keys are 0, then go to READY.
  - DONE: finished=1; ignore keys; leave only on reset.
- Latency: advance or wrong is asserted exactly 1 cycle after the debounced edge. box is sampled in the edge cycle. The shifter updates box on the advance edge, so box is valid again before the next possible press.
- BCD decrement:
  - If ones≠0, ones-1.
  - If ones=0 and tens≠0, ones=9 and tens-1.
  - The count never goes below 00.
  - The decrement that reaches 00 still pulses advance, and the FSM enters DONE on the same cycle the count becomes 00.
- enable falling in any state other than DONE: return to IDLE the next cycle, keep the score, and drop any pending pulse. Re-enable resumes via ARM.
- Reset in the middle of a press or lockout: everything returns to its reset values immediately; no pulse is emitted.
- advance and wrong are never high in the same cycle.

Optional Feature:
Macro PENALTY_EN.
- Defined: a wrong press goes to PENALTY instead of RELEASE. PENALTY lasts PENALTY_CYCLES cycles with penalty_active=1 and all key edges ignored. It then goes to RELEASE. enable=0 aborts PENALTY to IDLE.
- Not defined: there is no PENALTY state, penalty_active is tied 0, and a wrong press goes straight to RELEASE.

Decomposition:
- Shared package pyon_pkg:
  - FSM state enum (IDLE, ARM, READY, RELEASE, PENALTY, DONE).
  - BOX_LEFT=1'b0, BOX_RIGHT=1'b1.
  - BCD digit typedef (4 bits).
  - CLK_HZ=50000000.
- One natural sub-module, key_debounce (synchroniser + debounce counter + rising-edge flag), instantiated twice.

Test Plan:
- All benches use DEBOUNCE_CYCLES=4 and PENALTY_CYCLES=8. Reset, then enable=1, box=0, keys idle. Press left for 10 cycles, then release. Required: one advance pulse exactly 1 cycle after the debounced edge; score goes 32->31; wrong stays 0.
- box=1, press left. Required: one wrong pulse, no advance, score stays 31. With PENALTY_EN, penalty_active is high for 8 cycles, and a right press inside that window is ignored.
- Toggle left 1-0-1-0 at a 2-cycle period, then hold it high. Required: exactly one advance; no pulses from the bounce.
- Preload the count to 10 with correct presses, then give one more correct press. Required: score 09 (ones wraps 0->9, tens 1->0).
- From 01, give a correct press. Required: advance pulses, score 00, finished=1. Later presses produce no pulses. Only resetn=0 restores 32 and finished=0.
- Hold right during reset release, then enable=1. Required: no pulse until right is released and pressed again. Also drop enable mid-hold: IDLE, score kept, no pulse.

Source files
------------

// File: rtl/player_step_ctrl_pkg.sv
// Shared types and constants for the race-game player step controller.
package pyon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READY,
    RELEASE,
    PENALTY,
    DONE
  } state_t;

  localparam logic BOX_LEFT  = 1'b0;
  localparam logic BOX_RIGHT = 1'b1;

  typedef logic [3:0] bcd_t;

  localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/player_step_ctrl_if.sv
// Key/box inputs and judged-move outputs of player_step_ctrl.
interface player_step_ctrl_if;
  import pyon_pkg::*;

  logic enable;
  logic left;
  logic right;
  logic box;
  logic advance;
  logic wrong;
  bcd_t score_ones;
  bcd_t score_tens;
  logic finished;
  logic penalty_active;

  modport master (
    output enable, left, right, box,
    input  advance, wrong, score_ones, score_tens, finished, penalty_active
  );

  modport slave (
    input  enable, left, right, box,
    output advance, wrong, score_ones, score_tens, finished, penalty_active
  );
endinterface

// File: rtl/player_step_ctrl_key_debounce.sv
// 2-FF synchroniser, stable-count debouncer and registered rising-edge flag.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic level,
  output logic rise
);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Any cycle where the input matches the accepted level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/player_step_ctrl.sv
// Judges debounced key presses against the next box and counts remaining boxes in BCD.
// Optional wrong-press lockout is built when PENALTY_EN is defined.
module player_step_ctrl
  import pyon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20,
  parameter bcd_t        START_TENS      = 4'd3,
  parameter bcd_t        START_ONES      = 4'd2,
  parameter int unsigned PENALTY_CYCLES  = 25000000
) (
  input  logic                clk,
  input  logic                resetn,
  player_step_ctrl_if.slave   bus
);
  if (DEBOUNCE_CYCLES == 0 || PENALTY_CYCLES == 0) begin : g_bad_cfg
    $error("player_step_ctrl: cycle counts must be non-zero");
  end

  logic   lvl_l, lvl_r, rise_l, rise_r;
  state_t state_q, state_d;
  logic   advance_q, advance_d;
  logic   wrong_q, wrong_d;
  logic   finished_q, finished_d;
  bcd_t   tens_q, tens_d, ones_q, ones_d;
  logic   keys_idle, hit, last_box;

`ifdef PENALTY_EN
  localparam int unsigned PEN_W = $clog2(PENALTY_CYCLES) + 1;
  localparam logic [PEN_W-1:0] PEN_LAST = PEN_W'(PENALTY_CYCLES - 1);
  logic [PEN_W-1:0] pen_q, pen_d;
`endif

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_left (
    .clk(clk), .rst_n(resetn), .key_in(bus.left), .level(lvl_l), .rise(rise_l)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_right (
    .clk(clk), .rst_n(resetn), .key_in(bus.right), .level(lvl_r), .rise(rise_r)
  );

  assign keys_idle = ~lvl_l & ~lvl_r;
  assign hit       = (rise_l ^ rise_r) &
                     (rise_l ? (bus.box == BOX_LEFT) : (bus.box == BOX_RIGHT));
  assign last_box  = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_comb begin
    state_d    = state_q;
    advance_d  = 1'b0;
    wrong_d    = 1'b0;
    finished_d = finished_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
`ifdef PENALTY_EN
    pen_d      = '0;
`endif
    if (!bus.enable && state_q != DONE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!finished_q) state_d = ARM;
        ARM:     if (keys_idle) state_d = READY;
        READY: begin
          if (rise_l | rise_r) begin
            if (hit) begin
              advance_d = 1'b1;
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
              if (last_box) begin
                state_d    = DONE;
                finished_d = 1'b1;
              end else begin
                state_d = RELEASE;
              end
            end else begin
              wrong_d = 1'b1;
`ifdef PENALTY_EN
              state_d = PENALTY;
`else
              state_d = RELEASE;
`endif
            end
          end
        end
        RELEASE: if (keys_idle) state_d = READY;
`ifdef PENALTY_EN
        PENALTY: begin
          pen_d = pen_q + 1'b1;
          if (pen_q == PEN_LAST) state_d = RELEASE;
        end
`endif
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      advance_q  <= 1'b0;
      wrong_q    <= 1'b0;
      finished_q <= 1'b0;
      tens_q     <= START_TENS;
      ones_q     <= START_ONES;
`ifdef PENALTY_EN
      pen_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      advance_q  <= advance_d;
      wrong_q    <= wrong_d;
      finished_q <= finished_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
`ifdef PENALTY_EN
      pen_q      <= pen_d;
`endif
    end
  end

  assign bus.advance    = advance_q;
  assign bus.wrong      = wrong_q;
  assign bus.finished   = finished_q;
  assign bus.score_tens = tens_q;
  assign bus.score_ones = ones_q;
`ifdef PENALTY_EN
  assign bus.penalty_active = (state_q == PENALTY);
`else
  assign bus.penalty_active = 1'b0;
`endif
endmodule

// File: tb/tb_player_step_ctrl.sv
// Directed self-checking bench for player_step_ctrl (DEBOUNCE_CYCLES=4, PENALTY_CYCLES=8).
module tb_player_step_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   step_idx, adv_cnt, wr_cnt, first_adv, pen_cnt;
  int   both_cnt = 0;

  always #5 clk = ~clk;

  player_step_ctrl_if bus ();

  player_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(20),
    .START_TENS(4'd3),
    .START_ONES(4'd2),
    .PENALTY_CYCLES(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  task automatic clr();
    step_idx = 0; adv_cnt = 0; wr_cnt = 0; first_adv = 0; pen_cnt = 0;
  endtask

  task automatic step(input logic l, input logic r);
    bus.left = l;
    bus.right = r;
    @(posedge clk); #1;
    step_idx++;
    if (bus.advance) begin
      adv_cnt++;
      if (first_adv == 0) first_adv = step_idx;
    end
    if (bus.wrong) wr_cnt++;
    if (bus.advance && bus.wrong) both_cnt++;
    if (bus.penalty_active) pen_cnt++;
  endtask

  task automatic press(input logic l, input logic r, input logic b);
    bus.box = b;
    repeat (10) step(l, r);
    repeat (10) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h32) begin
      $display("FAIL reset_score got=%h exp=32", {bus.score_tens, bus.score_ones}); fails++;
    end
    tests++;
    if ({bus.advance, bus.wrong, bus.finished, bus.penalty_active} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.advance, bus.wrong, bus.finished, bus.penalty_active}); fails++;
    end
  endtask

  task automatic test_correct_press();
    bus.enable = 1'b1; bus.box = 1'b0;
    repeat (4) step(1'b0, 1'b0);
    clr();
    press(1'b1, 1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 1) begin $display("FAIL correct_adv_count got=%0d exp=1", adv_cnt); fails++; end
    tests++;
    if (first_adv !== 7) begin $display("FAIL correct_adv_latency got=%0d exp=7", first_adv); fails++; end
    tests++;
    if (wr_cnt !== 0) begin $display("FAIL correct_wrong got=%0d exp=0", wr_cnt); fails++; end
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h31) begin
      $display("FAIL correct_score got=%h exp=31", {bus.score_tens, bus.score_ones}); fails++;
    end
  endtask

  task automatic test_wrong_press();
    bus.box = 1'b1;
    clr();
    // Right rises inside the lockout / release window and must be ignored.
    for (int s = 1; s <= 30; s++) step(s <= 10, s >= 3 && s <= 10);
    tests++;
    if (wr_cnt !== 1 || adv_cnt !== 0) begin
      $display("FAIL wrong_pulses got wr=%0d adv=%0d exp wr=1 adv=0", wr_cnt, adv_cnt); fails++;
    end
    tests++;
`ifdef PENALTY_EN
    if (pen_cnt !== 8) begin $display("FAIL penalty_len got=%0d exp=8", pen_cnt); fails++; end
`else
    if (pen_cnt !== 0) begin $display("FAIL penalty_tied got=%0d exp=0", pen_cnt); fails++; end
`endif
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h31) begin
      $display("FAIL wrong_score got=%h exp=31", {bus.score_tens, bus.score_ones}); fails++;
    end
    clr();
    bus.box = 1'b0;
    repeat (10) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    tests++;
    if (wr_cnt !== 1 || adv_cnt !== 0) begin
      $display("FAIL both_keys got wr=%0d adv=%0d exp wr=1 adv=0", wr_cnt, adv_cnt); fails++;
    end
  endtask

  task automatic test_bounce();
    bus.box = 1'b0;
    clr();
    for (int s = 0; s < 8; s++) step(((s / 2) % 2) == 0, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 1 || wr_cnt !== 0) begin
      $display("FAIL bounce_pulses got adv=%0d wr=%0d exp adv=1 wr=0", adv_cnt, wr_cnt); fails++;
    end
    tests++;
    if (first_adv !== 15) begin $display("FAIL bounce_latency got=%0d exp=15", first_adv); fails++; end
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h30) begin
      $display("FAIL bounce_score got=%h exp=30", {bus.score_tens, bus.score_ones}); fails++;
    end
  endtask

  task automatic test_bcd_borrow();
    repeat (20) press(1'b0, 1'b1, 1'b1);
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h10) begin
      $display("FAIL preload_score got=%h exp=10", {bus.score_tens, bus.score_ones}); fails++;
    end
    press(1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.score_tens, bus.score_ones} !== 8'h09) begin
      $display("FAIL borrow_score got=%h exp=09", {bus.score_tens, bus.score_ones}); fails++;
    end
  endtask

  task automatic test_finish();
    repeat (8) press(1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.score_tens, bus.score_ones, bus.finished} !== 9'h02) begin
      $display("FAIL pre_finish got=%h exp=002", {bus.score_tens, bus.score_ones, bus.finished}); fails++;
    end
    clr();
    press(1'b1, 1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 1 || {bus.score_tens, bus.score_ones} !== 8'h00 || bus.finished !== 1'b1) begin
      $display("FAIL final_step got adv=%0d score=%h fin=%b exp adv=1 score=00 fin=1",
               adv_cnt, {bus.score_tens, bus.score_ones}, bus.finished); fails++;
    end
    clr();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    bus.enable = 1'b0; repeat (3) step(1'b0, 1'b0);
    bus.enable = 1'b1; repeat (5) step(1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 0 || wr_cnt !== 0 || bus.finished !== 1'b1 ||
        {bus.score_tens, bus.score_ones} !== 8'h00) begin
      $display("FAIL done_ignores got adv=%0d wr=%0d fin=%b score=%h exp 0 0 1 00",
               adv_cnt, wr_cnt, bus.finished, {bus.score_tens, bus.score_ones}); fails++;
    end
    resetn = 1'b0; #2;
    tests++;
    if ({bus.score_tens, bus.score_ones, bus.finished} !== 9'h064) begin
      $display("FAIL reset_restore got=%h exp=064", {bus.score_tens, bus.score_ones, bus.finished}); fails++;
    end
  endtask

  task automatic test_held_at_reset();
    bus.enable = 1'b0; bus.box = 1'b1;
    repeat (2) step(1'b0, 1'b1);
    resetn = 1'b1;
    repeat (10) step(1'b0, 1'b1);
    bus.enable = 1'b1;
    clr();
    repeat (10) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 0 || wr_cnt !== 0) begin
      $display("FAIL held_key got adv=%0d wr=%0d exp 0 0", adv_cnt, wr_cnt); fails++;
    end
    press(1'b0, 1'b1, 1'b1);
    tests++;
    if (adv_cnt !== 1 || {bus.score_tens, bus.score_ones} !== 8'h31) begin
      $display("FAIL repress got adv=%0d score=%h exp adv=1 score=31",
               adv_cnt, {bus.score_tens, bus.score_ones}); fails++;
    end
  endtask

  task automatic test_enable_drop();
    bus.box = 1'b0;
    clr();
    repeat (6) step(1'b1, 1'b0);
    bus.enable = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 0 || wr_cnt !== 0 || {bus.score_tens, bus.score_ones} !== 8'h31) begin
      $display("FAIL enable_drop got adv=%0d wr=%0d score=%h exp 0 0 31",
               adv_cnt, wr_cnt, {bus.score_tens, bus.score_ones}); fails++;
    end
    bus.enable = 1'b1;
    repeat (4) step(1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tests++;
    if (adv_cnt !== 1 || {bus.score_tens, bus.score_ones} !== 8'h30) begin
      $display("FAIL resume got adv=%0d score=%h exp adv=1 score=30",
               adv_cnt, {bus.score_tens, bus.score_ones}); fails++;
    end
    tests++;
    if (both_cnt !== 0) begin $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); fails++; end
  endtask

  initial begin
    bus.enable = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.box = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    test_correct_press();
    test_wrong_press();
    test_bounce();
    test_bcd_borrow();
    test_finish();
    test_held_at_reset();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
